// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem peripheral interconnect.
// Page decode is addr[31:24]; slave index is addr[23:16].
package iomem_pkg;

    localparam int IOMEM_PAGE_W = 8;
    localparam int IOMEM_IDX_W  = 8;

    localparam logic [31:0]             IOMEM_ERR_DATA  = 32'hDEAD_BEEF;
    localparam logic [IOMEM_PAGE_W-1:0] IOMEM_BASE_PAGE = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } iomem_state_e;

    function automatic logic [IOMEM_PAGE_W-1:0] iomem_page(input logic [31:0] addr);
        return addr[31:24];
    endfunction

    function automatic logic [IOMEM_IDX_W-1:0] iomem_idx(input logic [31:0] addr);
        return addr[23:16];
    endfunction

endpackage

// File: rtl/iomem_rdata_mux.sv
// Selects one slave's 32-bit read word from the concatenated bus; combinational.
// Out-of-range selects return zero.
module iomem_rdata_mux
    import iomem_pkg::*;
#(
    parameter int NSLAVES = 4
) (
    input  logic [IOMEM_IDX_W-1:0]  sel_i,
    input  logic [32*NSLAVES-1:0]   s_rdata_i,
    output logic [31:0]             rdata_o
);

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (sel_i == IOMEM_IDX_W'(i)) begin
                rdata_o = s_rdata_i[32*i +: 32];
            end
        end
    end

endmodule

// File: rtl/iomem_interconnect.sv
// Single-master iomem fan-out: registered request to one slave, one registered response back.
// Slave ready 1 cycle after s_valid at best; a silent slave is cut off by the timeout guard.
module iomem_interconnect
    import iomem_pkg::*;
#(
    parameter int                        NSLAVES        = 4,
    parameter logic [IOMEM_PAGE_W-1:0]   BASE_PAGE      = IOMEM_BASE_PAGE,
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               ERR_DATA       = IOMEM_ERR_DATA
) (
    input  logic                    clk,
    input  logic                    resetn,

    input  logic                    iomem_valid,
    output logic                    iomem_ready,
    input  logic [3:0]              iomem_wstrb,
    input  logic [31:0]             iomem_addr,
    input  logic [31:0]             iomem_wdata,
    output logic [31:0]             iomem_rdata,

    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    output logic [3:0]              s_wstrb,
    output logic [15:0]             s_addr,
    output logic [31:0]             s_wdata,
    input  logic [32*NSLAVES-1:0]   s_rdata,

    output logic                    err,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    iomem_state_e        state_q, state_d;
    logic                ready_q, ready_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
    logic [3:0]          s_wstrb_q, s_wstrb_d;
    logic [31:0]         s_wdata_q, s_wdata_d;
    logic [31:0]         addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [31:0]         err_addr_q, err_addr_d;

    logic                req_hit;
    logic                idx_ok;
    logic                sel_ready;
    logic                tmo_hit;
    logic                err_set;
    logic [31:0]         err_set_addr;
    logic [31:0]         slave_rdata;

    // Select by the latched index so rdata never depends on the live master address.
    iomem_rdata_mux #(
        .NSLAVES   (NSLAVES)
    ) u_rdata_mux (
        .sel_i     (iomem_idx(addr_q)),
        .s_rdata_i (s_rdata),
        .rdata_o   (slave_rdata)
    );

    assign req_hit   = iomem_valid && !ready_q && (iomem_page(iomem_addr) == BASE_PAGE);
    assign idx_ok    = int'(iomem_idx(iomem_addr)) < NSLAVES;
    assign sel_ready = |(s_ready & s_valid_q);
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        ready_d      = ready_q;
        rdata_d      = rdata_q;
        s_valid_d    = s_valid_q;
        s_wstrb_d    = s_wstrb_q;
        s_wdata_d    = s_wdata_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_set      = 1'b0;
        err_set_addr = err_addr_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req_hit) begin
                    if (idx_ok) begin
                        s_wstrb_d = iomem_wstrb;
                        s_wdata_d = iomem_wdata;
                        addr_d    = iomem_addr;
                        s_valid_d = NSLAVES'(1) << iomem_idx(iomem_addr);
                        state_d   = ST_WAIT;
                    end else begin
                        rdata_d      = ERR_DATA;
                        err_set      = 1'b1;
                        err_set_addr = iomem_addr;
                        ready_d      = 1'b1;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                // Ready is checked first so a response on the timeout cycle still wins.
                if (sel_ready) begin
                    rdata_d   = slave_rdata;
                    s_valid_d = '0;
                    ready_d   = 1'b1;
                    state_d   = ST_RESP;
                end else if (tmo_hit) begin
                    rdata_d      = ERR_DATA;
                    s_valid_d    = '0;
                    err_set      = 1'b1;
                    err_set_addr = addr_q;
                    ready_d      = 1'b1;
                    state_d      = ST_RESP;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                ready_d = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                ready_d   = 1'b0;
                s_valid_d = '0;
                cnt_d     = '0;
                state_d   = ST_IDLE;
            end
        endcase

        err_d      = err_set | (err_q & ~err_clr);
        err_addr_d = err_set ? err_set_addr : err_addr_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            s_valid_q  <= '0;
            s_wstrb_q  <= '0;
            s_wdata_q  <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            s_valid_q  <= s_valid_d;
            s_wstrb_q  <= s_wstrb_d;
            s_wdata_q  <= s_wdata_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign s_valid     = s_valid_q;
    assign s_wstrb     = s_wstrb_q;
    assign s_addr      = addr_q[15:0];
    assign s_wdata     = s_wdata_q;
    assign err         = err_q;
    assign err_addr    = err_addr_q;

endmodule

// File: tb/tb_iomem_interconnect.sv
// Bench for iomem_interconnect: transaction-level model checked every cycle plus directed literal checks.
module tb_iomem_interconnect;

    localparam int NS  = 4;
    localparam int TMO = 8;

    logic           clk = 1'b0;
    logic           resetn;
    logic           iomem_valid;
    logic           iomem_ready;
    logic [3:0]     iomem_wstrb;
    logic [31:0]    iomem_addr;
    logic [31:0]    iomem_wdata;
    logic [31:0]    iomem_rdata;
    logic [NS-1:0]  s_valid;
    logic [NS-1:0]  s_ready;
    logic [3:0]     s_wstrb;
    logic [15:0]    s_addr;
    logic [31:0]    s_wdata;
    logic [32*NS-1:0] s_rdata;
    logic           err;
    logic [31:0]    err_addr;
    logic           err_clr;

    iomem_interconnect #(
        .NSLAVES        (NS),
        .BASE_PAGE      (8'h03),
        .TIMEOUT_CYCLES (TMO),
        .ERR_DATA       (32'hDEAD_BEEF)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_rdata     (s_rdata),
        .err         (err),
        .err_addr    (err_addr),
        .err_clr     (err_clr)
    );

    initial forever #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Slave behaviour: ready after dly[i] extra cycles of valid; -1 never; always_rdy forces ready.
    int          dly [NS] = '{0, 0, 0, 0};
    logic [31:0] srd [NS] = '{32'h0, 32'h0, 32'h0, 32'h0};
    logic [NS-1:0] always_rdy = '0;
    int          vcnt [NS] = '{0, 0, 0, 0};

    initial begin
        s_ready = '0;
        s_rdata = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < NS; i++) begin
                if (s_valid[i] === 1'b1) vcnt[i]++;
                else vcnt[i] = 0;
                s_ready[i] = always_rdy[i] || ((s_valid[i] === 1'b1) && dly[i] >= 0 && vcnt[i] > dly[i]);
                s_rdata[32*i +: 32] = srd[i];
            end
        end
    end

    // Reference model: what the master and slaves must observe, tracked per transfer.
    logic [NS-1:0] m_sv       = '0;
    logic          m_rdy      = 1'b0;
    logic [31:0]   m_rdata    = '0;
    logic [31:0]   m_addr     = '0;
    logic [31:0]   m_wdata    = '0;
    logic [3:0]    m_wstrb    = '0;
    logic          m_err      = 1'b0;
    logic [31:0]   m_err_addr = '0;
    int            m_idx      = 0;
    int            m_waited   = 0;
    logic          m_set;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_sv = '0; m_rdy = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
            m_wstrb = '0; m_err = 1'b0; m_err_addr = '0; m_waited = 0;
        end else begin
            m_set = 1'b0;
            if (m_rdy) begin
                m_rdy = 1'b0;
            end else if (m_sv != 0) begin
                if ((s_ready & m_sv) != 0) begin
                    m_rdata = s_rdata[32*m_idx +: 32];
                    m_sv    = '0;
                    m_rdy   = 1'b1;
                end else begin
                    m_waited++;
                    if (TMO != 0 && m_waited == TMO) begin
                        m_sv = '0; m_rdy = 1'b1; m_rdata = 32'hDEAD_BEEF;
                        m_set = 1'b1; m_err_addr = m_addr;
                    end
                end
            end else if (iomem_valid && iomem_addr[31:24] == 8'h03) begin
                if (int'(iomem_addr[23:16]) < NS) begin
                    m_idx    = int'(iomem_addr[23:16]);
                    m_sv     = NS'(1) << m_idx;
                    m_addr   = iomem_addr;
                    m_wdata  = iomem_wdata;
                    m_wstrb  = iomem_wstrb;
                    m_waited = 0;
                end else begin
                    m_rdy = 1'b1; m_rdata = 32'hDEAD_BEEF;
                    m_set = 1'b1; m_err_addr = iomem_addr;
                end
            end
            if (m_set) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("mdl_ready",    32'(iomem_ready), 32'(m_rdy));
        chk("mdl_s_valid",  32'(s_valid),     32'(m_sv));
        chk("mdl_err",      32'(err),         32'(m_err));
        chk("mdl_err_addr", err_addr,         m_err_addr);
        if (m_rdy) chk("mdl_rdata", iomem_rdata, m_rdata);
        if (m_sv != 0) begin
            chk("mdl_s_addr",  32'(s_addr),  32'(m_addr[15:0]));
            chk("mdl_s_wstrb", 32'(s_wstrb), 32'(m_wstrb));
            chk("mdl_s_wdata", s_wdata,      m_wdata);
        end
    end

    int            pulses = 0;
    logic [NS-1:0] sv_prev = '0;
    always @(negedge clk) begin
        if (s_valid != 0 && sv_prev == 0) pulses++;
        sv_prev = s_valid;
    end

    // Results of the most recent xfer call.
    int            r_lat, r_svc, r_pulses;
    logic          r_got;
    logic [31:0]   r_rd;
    logic [NS-1:0] r_seen, r_sv1, r_sv_rdy;
    logic [15:0]   r_saddr1;

    task automatic xfer(input logic [31:0] addr, input logic [3:0] wstrb,
                        input logic [31:0] wdata, input logic clr);
        int t;
        int p0;
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = wstrb;
        iomem_wdata = wdata; err_clr = clr;
        t = 0; r_got = 1'b0; r_seen = '0; r_svc = 0; p0 = pulses;
        r_sv1 = '0; r_saddr1 = '0; r_sv_rdy = '0; r_rd = '0; r_lat = -1;
        while (!r_got && t < 40) begin
            @(negedge clk);
            r_seen |= s_valid;
            if (s_valid != 0) r_svc++;
            if (t == 1) begin r_sv1 = s_valid; r_saddr1 = s_addr; end
            if (iomem_ready) begin
                r_got = 1'b1; r_lat = t; r_rd = iomem_rdata; r_sv_rdy = s_valid;
            end else begin
                @(posedge clk); #1;
                err_clr = 1'b0;
                t++;
            end
        end
        @(posedge clk); #1;
        iomem_valid = 1'b0; err_clr = 1'b0;
        r_pulses = pulses - p0;
        if (!r_got) chk("xfer_response_timeout", 32'(r_got), 32'd1);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_rdy, n_sv;
        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = '0; iomem_addr = '0;
        iomem_wdata = '0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",    32'(iomem_ready), 32'd0);
        chk("rst_rdata",    iomem_rdata,      32'd0);
        chk("rst_s_valid",  32'(s_valid),     32'd0);
        chk("rst_s_addr",   32'(s_addr),      32'd0);
        chk("rst_s_wstrb",  32'(s_wstrb),     32'd0);
        chk("rst_s_wdata",  s_wdata,          32'd0);
        chk("rst_err",      32'(err),         32'd0);
        chk("rst_err_addr", err_addr,         32'd0);
        @(posedge clk); #1; resetn = 1'b1;

        // Write to slave 1, ready in its first valid cycle.
        dly[1] = 0; srd[1] = 32'h5A5A_0001;
        xfer(32'h0301_0004, 4'hF, 32'h1234_5678, 1'b0);
        chk("wr1_latency", 32'(r_lat),    32'd2);
        chk("wr1_sv_T1",   32'(r_sv1),    32'b0010);
        chk("wr1_addr_T1", 32'(r_saddr1), 32'h0004);
        chk("wr1_svc",     32'(r_svc),    32'd1);
        chk("wr1_pulses",  32'(r_pulses), 32'd1);
        chk("wr1_rdata",   r_rd,          32'h5A5A_0001);
        chk("wr1_err",     32'(err),      32'd0);

        // Read slave 2 with 3 wait cycles; slave 3 asserts ready unselected.
        dly[2] = 3; srd[2] = 32'hCAFE_F00D; always_rdy[3] = 1'b1;
        xfer(32'h0302_0000, 4'h0, 32'h0, 1'b0);
        chk("rd2_latency", 32'(r_lat),    32'd5);
        chk("rd2_rdata",   r_rd,          32'hCAFE_F00D);
        chk("rd2_sv_rdy",  32'(r_sv_rdy), 32'd0);
        chk("rd2_seen",    32'(r_seen),   32'b0100);
        chk("rd2_svc",     32'(r_svc),    32'd4);
        chk("rd2_pulses",  32'(r_pulses), 32'd1);
        always_rdy[3] = 1'b0;

        // Partial-strobe write to slave 3, registered two cycles later.
        dly[3] = 2; srd[3] = 32'h0000_3333;
        xfer(32'h0303_ABCC, 4'b0110, 32'hA5A5_5A5A, 1'b0);
        chk("wr3_latency", 32'(r_lat),  32'd4);
        chk("wr3_seen",    32'(r_seen), 32'b1000);

        // Decode error.
        xfer(32'h0307_0000, 4'h0, 32'h0, 1'b0);
        chk("dec_latency",  32'(r_lat),    32'd1);
        chk("dec_rdata",    r_rd,          32'hDEAD_BEEF);
        chk("dec_err",      32'(err),      32'd1);
        chk("dec_err_addr", err_addr,      32'h0307_0000);
        chk("dec_seen",     32'(r_seen),   32'd0);
        chk("dec_pulses",   32'(r_pulses), 32'd0);
        pulse_clr();
        chk("clr_err",      32'(err), 32'd0);
        chk("clr_err_addr", err_addr, 32'h0307_0000);

        // Dead slave 0 hits the timeout.
        dly[0] = -1;
        xfer(32'h0300_0010, 4'h0, 32'h0, 1'b0);
        chk("tmo_latency",  32'(r_lat),    32'd9);
        chk("tmo_svc",      32'(r_svc),    32'd8);
        chk("tmo_rdata",    r_rd,          32'hDEAD_BEEF);
        chk("tmo_err",      32'(err),      32'd1);
        chk("tmo_err_addr", err_addr,      32'h0300_0010);
        chk("tmo_pulses",   32'(r_pulses), 32'd1);

        // Clear and new error in the same cycle: set wins.
        xfer(32'h0309_0000, 4'h0, 32'h0, 1'b1);
        chk("setclr_latency",  32'(r_lat), 32'd1);
        chk("setclr_err",      32'(err),   32'd1);
        chk("setclr_err_addr", err_addr,   32'h0309_0000);

        // Foreign page is ignored entirely.
        n_rdy = 0; n_sv = 0;
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = 32'h0200_0000; iomem_wstrb = 4'h0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (iomem_ready) n_rdy++;
            if (s_valid != 0) n_sv++;
        end
        @(posedge clk); #1; iomem_valid = 1'b0;
        chk("page_ready", 32'(n_rdy), 32'd0);
        chk("page_sv",    32'(n_sv),  32'd0);

        // Reset while a transfer waits on a dead slave.
        dly[0] = -1;
        @(posedge clk); #1;
        iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_sv",  32'(s_valid), 32'b0001);
        resetn = 1'b0; iomem_valid = 1'b0;
        #1;
        chk("async_rst_sv",    32'(s_valid),     32'd0);
        chk("async_rst_ready", 32'(iomem_ready), 32'd0);
        chk("async_rst_err",   32'(err),         32'd0);
        repeat (2) @(posedge clk);
        #1; resetn = 1'b1;

        dly[0] = 1; srd[0] = 32'h0BAD_F00D;
        xfer(32'h0300_0008, 4'h0, 32'h0, 1'b0);
        chk("post_latency", 32'(r_lat),    32'd3);
        chk("post_rdata",   r_rd,          32'h0BAD_F00D);
        chk("post_err",     32'(err),      32'd0);
        chk("post_pulses",  32'(r_pulses), 32'd1);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
